// File: rtl/mem_bus_arbiter_if.sv
// Bundles the I-side refill port, D-side word port and backing-memory port.
// slave = arbiter view; master = requesters plus memory model view.
interface mem_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic [1:0]  i_status;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic [1:0]  d_status;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_rdata, i_rvalid, i_status, d_rdata, d_status,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_rdata, i_rvalid, i_status, d_rdata, d_status,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates I-side line refills and D-side word accesses onto one memory port; mem_req rises one cycle after grant.
// Memory backpressure via mem_ready stalls the current beat indefinitely; one transaction outstanding at a time.
module mem_bus_arbiter #(
    parameter int LINE_WORDS   = 4,
    parameter int MAX_D_STREAK = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_bus_arbiter_if.slave bus
);

    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
    localparam logic [3:0]        STREAK_MAX = 4'(MAX_D_STREAK);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_I_BURST = 3'd1;
    localparam logic [2:0] ST_D_XFER  = 3'd2;
    localparam logic [2:0] ST_I_DONE  = 3'd3;
    localparam logic [2:0] ST_D_DONE  = 3'd4;

    logic [2:0]        state;
    logic [BEAT_W-1:0] beat;
    logic [3:0]        d_streak;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [31:0]       d_rdata_q;
    logic              grant_d;
    logic              grant_i;

    // D wins ties until it has starved a waiting I request MAX_D_STREAK times in a row.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.d_req && !(bus.i_req && d_streak == STREAK_MAX)) begin
                grant_d = 1'b1;
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat      <= '0;
            d_streak  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        state   <= ST_D_XFER;
                        addr_q  <= bus.d_addr;
                        we_q    <= bus.d_we;
                        wdata_q <= bus.d_wdata;
                        if (bus.i_req && d_streak != STREAK_MAX) begin
                            d_streak <= d_streak + 4'd1;
                        end
                    end else if (grant_i) begin
                        state    <= ST_I_BURST;
                        addr_q   <= bus.i_addr;
                        we_q     <= 1'b0;
                        beat     <= '0;
                        d_streak <= '0;
                    end
                end
                ST_D_XFER: begin
                    if (bus.mem_ready) begin
                        if (!we_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                        state <= ST_D_DONE;
                    end
                end
                ST_I_BURST: begin
                    if (bus.mem_ready) begin
                        addr_q <= addr_q + 32'd4;
                        beat   <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            state <= ST_I_DONE;
                        end
                    end
                end
                ST_I_DONE, ST_D_DONE: state <= ST_IDLE;
                default:              state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = (state == ST_I_BURST) || (state == ST_D_XFER);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Refill beats are forwarded in the completing cycle rather than re-registered.
    assign bus.i_rvalid = (state == ST_I_BURST) && bus.mem_ready;
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : 32'd0;
    assign bus.d_rdata  = d_rdata_q;

    assign bus.i_status = rst ? 2'b00 : (state == ST_I_DONE) ? 2'b10 : {1'b0, bus.i_req};
    assign bus.d_status = rst ? 2'b00 : (state == ST_D_DONE) ? 2'b10 : {1'b0, bus.d_req};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by random traffic, checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int LW   = 4;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.LINE_WORDS(LW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: kind of transaction in flight (0 none, 1 refill, 2 data), pending done report.
    int          m_kind = 0;
    int          m_done = 0;
    int          m_streak = 0;
    int          m_beat = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_wdata = '0;
    logic        m_we = 1'b0;
    logic [31:0] m_drdata = '0;

    int          obs_beats = 0, obs_rvalid = 0, obs_idone = 0, obs_ddone = 0, cyc_n = 0;
    logic [31:0] last_mem_addr = '0;
    logic [31:0] rv_addr[$];
    int          rv_cyc[$];
    int          done_log[$];
    logic        i_done_now = 1'b0, d_done_now = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic [1:0] e_is, e_ds;
        #1;
        if (rst) begin
            chk("rst_mem_req",   32'(bus.mem_req),  32'd0);
            chk("rst_mem_we",    32'(bus.mem_we),   32'd0);
            chk("rst_mem_addr",  bus.mem_addr,      32'd0);
            chk("rst_mem_wdata", bus.mem_wdata,     32'd0);
            chk("rst_i_rvalid",  32'(bus.i_rvalid), 32'd0);
            chk("rst_i_rdata",   bus.i_rdata,       32'd0);
            chk("rst_d_rdata",   bus.d_rdata,       32'd0);
            chk("rst_i_status",  32'(bus.i_status), 32'd0);
            chk("rst_d_status",  32'(bus.d_status), 32'd0);
        end else begin
            chk("mem_req", 32'(bus.mem_req), 32'(m_kind != 0));
            if (m_kind == 2) begin
                chk("d_mem_addr",  bus.mem_addr,     m_base);
                chk("d_mem_we",    32'(bus.mem_we),  32'(m_we));
                chk("d_mem_wdata", bus.mem_wdata,    m_wdata);
            end
            if (m_kind == 1) begin
                chk("i_mem_addr", bus.mem_addr,    m_base + 32'(4 * m_beat));
                chk("i_mem_we",   32'(bus.mem_we), 32'd0);
            end
            chk("i_rvalid", 32'(bus.i_rvalid), 32'(m_kind == 1 && bus.mem_ready));
            if (m_kind == 1 && bus.mem_ready) chk("i_rdata", bus.i_rdata, bus.mem_rdata);
            e_is = (m_done == 1) ? 2'b10 : (bus.i_req ? 2'b01 : 2'b00);
            e_ds = (m_done == 2) ? 2'b10 : (bus.d_req ? 2'b01 : 2'b00);
            chk("i_status", 32'(bus.i_status), 32'(e_is));
            chk("d_status", 32'(bus.d_status), 32'(e_ds));
            chk("d_rdata",  bus.d_rdata,       m_drdata);
        end
        if (bus.mem_req && bus.mem_ready) begin
            obs_beats++;
            last_mem_addr = bus.mem_addr;
        end
        if (bus.i_rvalid) begin
            obs_rvalid++;
            rv_addr.push_back(bus.mem_addr);
            rv_cyc.push_back(cyc_n);
        end
        i_done_now = (bus.i_status == 2'b10);
        d_done_now = (bus.d_status == 2'b10);
        if (i_done_now) begin obs_idone++; done_log.push_back(1); end
        if (d_done_now) begin obs_ddone++; done_log.push_back(2); end
    endtask

    task automatic advance();
        logic r, ir, dr, dwe, mr;
        logic [31:0] ia, da, dwd, mrd;
        r = rst; ir = bus.i_req; dr = bus.d_req; dwe = bus.d_we; mr = bus.mem_ready;
        ia = bus.i_addr; da = bus.d_addr; dwd = bus.d_wdata; mrd = bus.mem_rdata;
        @(posedge clk);
        if (r) begin
            m_kind = 0; m_done = 0; m_streak = 0; m_beat = 0; m_drdata = '0;
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (m_kind == 2) begin
            if (mr) begin
                if (!m_we) m_drdata = mrd;
                m_kind = 0;
                m_done = 2;
            end
        end else if (m_kind == 1) begin
            if (mr) begin
                m_beat++;
                if (m_beat == LW) begin m_kind = 0; m_done = 1; end
            end
        end else if (dr && !(ir && m_streak == MAXS)) begin
            m_kind = 2; m_base = da; m_we = dwe; m_wdata = dwd;
            if (ir && m_streak < MAXS) m_streak++;
        end else if (ir) begin
            m_kind = 1; m_base = ia; m_beat = 0; m_streak = 0;
        end
        #1;
        if (i_done_now) bus.i_req = 1'b0;
        if (d_done_now) bus.d_req = 1'b0;
        cyc_n++;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int b0, d0, i0, r0;
        logic [31:0] saved, tmp;

        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;
        @(posedge clk); #1;
        run(2);
        rst = 1'b0;
        run(2);

        // D read with three stall cycles
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000; bus.mem_rdata = 32'hDEADBEEF;
        b0 = obs_beats; d0 = obs_ddone;
        for (int k = 0; k < 10; k++) begin
            bus.mem_ready = (k >= 4);
            cycle();
        end
        chk("dread_beats", 32'(obs_beats - b0), 32'd1);
        chk("dread_addr",  last_mem_addr,       32'h1000);
        chk("dread_data",  bus.d_rdata,         32'hDEADBEEF);
        chk("dread_done",  32'(obs_ddone - d0), 32'd1);

        // I refill with memory always ready
        bus.i_req = 1; bus.i_addr = 32'h0040_0010; bus.mem_ready = 1;
        rv_addr.delete(); rv_cyc.delete(); r0 = obs_rvalid; i0 = obs_idone;
        for (int k = 0; k < 8; k++) begin
            bus.mem_rdata = $urandom;
            cycle();
        end
        chk("refill_pulses", 32'(obs_rvalid - r0), 32'd4);
        for (int j = 0; j < 4; j++) chk("refill_addr", rv_addr[j], 32'h0040_0010 + 32'(4 * j));
        chk("refill_consec", 32'(rv_cyc[3] - rv_cyc[0]), 32'd3);
        chk("refill_done",   32'(obs_idone - i0),        32'd1);

        // simultaneous requests: D first, then I
        done_log.delete();
        bus.i_req = 1; bus.i_addr = 32'h5000; bus.d_req = 1; bus.d_addr = 32'h6000; bus.d_we = 0;
        run(12);
        chk("tie_count",  32'(done_log.size()), 32'd2);
        chk("tie_first",  32'(done_log[0]),     32'd2);
        chk("tie_second", 32'(done_log[1]),     32'd1);

        // D streak limit with I continuously pending
        done_log.delete();
        bus.i_addr = 32'h7000;
        for (int k = 0; k < 40; k++) begin
            bus.i_req = 1; bus.d_req = 1;
            bus.d_addr = 32'h8000 + 32'(4 * k); bus.d_we = k[0]; bus.d_wdata = $urandom;
            bus.mem_rdata = $urandom;
            cycle();
        end
        for (int j = 0; j < 10; j++) chk("streak_order", 32'(done_log[j]), (j % 5 == 4) ? 32'd1 : 32'd2);
        bus.i_req = 0; bus.d_req = 0;
        run(12);

        // reset during beat 2 of a refill
        bus.i_req = 1; bus.i_addr = 32'h2000; bus.mem_ready = 1;
        run(3);
        i0 = obs_idone; r0 = obs_rvalid;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        chk("rst_no_done",   32'(obs_idone - i0),  32'd0);
        chk("rst_no_rvalid", 32'(obs_rvalid - r0), 32'd0);
        run(8);
        chk("post_rst_done",   32'(obs_idone - i0),  32'd1);
        chk("post_rst_rvalid", 32'(obs_rvalid - r0), 32'd4);

        // D write stalled ten cycles
        saved = m_drdata; d0 = obs_ddone;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h3000; bus.d_wdata = 32'hA5A5_0001; bus.mem_ready = 0;
        cycle();
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("wr_hold_req",   32'(bus.mem_req), 32'd1);
            chk("wr_hold_we",    32'(bus.mem_we),  32'd1);
            chk("wr_hold_addr",  bus.mem_addr,     32'h3000);
            chk("wr_hold_wdata", bus.mem_wdata,    32'hA5A5_0001);
            advance();
        end
        bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        cycle();
        bus.mem_ready = 0;
        run(3);
        chk("wr_rdata_kept", bus.d_rdata,         saved);
        chk("wr_done_once",  32'(obs_ddone - d0), 32'd1);

        // random traffic, occasional abandons and resets
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                tmp = $urandom;
                bus.i_req = 1; bus.i_addr = tmp & 32'hFFFF_FFF0;
            end else if (bus.i_req && $urandom_range(0, 40) == 0) begin
                bus.i_req = 0;
            end
            if (!bus.d_req && $urandom_range(0, 1) == 0) begin
                bus.d_req = 1; bus.d_addr = $urandom; bus.d_wdata = $urandom;
                bus.d_we = ($urandom_range(0, 1) == 1);
            end else if (bus.d_req && $urandom_range(0, 40) == 0) begin
                bus.d_req = 0;
            end
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            bus.mem_rdata = $urandom;
            cycle();
        end
        rst = 1'b0; bus.i_req = 0; bus.d_req = 0; bus.mem_ready = 1;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per I-side refill burst; power of two, 2..16.
REQ-002 Parameter MAX_D_STREAK, default 4, max consecutive D grants while I is pending; 1..15.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_req  in  1  I-side refill request; held high until i_status==2'b10.
REQ-006 i_addr  in  32  refill base address, line-aligned; sampled at grant.
REQ-007 i_rdata  out  32  refill beat data; valid when i_rvalid=1.
REQ-008 i_rvalid  out  1  one-cycle pulse per returned beat, in ascending address order.
REQ-009 i_status  out  2  2'b00 idle, 2'b01 busy, 2'b10 done.
REQ-010 d_req  in  1  D-side word access request; held high until d_status==2'b10.
REQ-011 d_we  in  1  1=write, 0=read; sampled at grant.
REQ-012 d_addr  in  32  word address; sampled at grant.
REQ-013 d_wdata  in  32  write data; sampled at grant.
REQ-014 d_rdata  out  32  read data; valid while d_status==2'b10.
REQ-015 d_status  out  2  same encoding as i_status.
REQ-016 mem_req  out  1  backing-memory request.
REQ-017 mem_we  out  1  backing-memory write enable.
REQ-018 mem_addr  out  32  backing-memory word address.
REQ-019 mem_wdata  out  32  backing-memory write data.
REQ-020 mem_ready  in  1  beat completes in any cycle with mem_req=1 and mem_ready=1.
REQ-021 mem_rdata  in  32  read data, valid in the completing cycle.

Function
REQ-022 FSM states IDLE, I_BURST, D_XFER, I_DONE, D_DONE.
REQ-023 IDLE: d_req only -> D_XFER; i_req only -> I_BURST; both -> D_XFER unless d_streak==MAX_D_STREAK, then I_BURST; none -> stay.
REQ-024 d_streak (4 bits): +1 on each D grant made while i_req=1, saturating at MAX_D_STREAK; cleared on any I grant.
REQ-025 Grant registers address/we/wdata; mem_req asserts the cycle after grant (first cycle in I_BURST/D_XFER).
REQ-026 mem_req, mem_addr, mem_we, mem_wdata stay stable until the completing cycle.
REQ-027 D_XFER: one beat; on completion, latch mem_rdata into d_rdata (reads only; writes leave d_rdata unchanged); go to D_DONE.
REQ-028 I_BURST: mem_we=0; beat counter from 0; mem_addr = base + 4*beat; each completion pulses i_rvalid with i_rdata=mem_rdata that cycle.
REQ-029 I_BURST: mem_req stays high across beats; after beat LINE_WORDS-1 completes, go to I_DONE.
REQ-030 mem_addr increments with 32-bit modulo wrap; no carry-out check.
REQ-031 Bursts and D transfers are non-preemptible; requests arriving meanwhile wait in IDLE arbitration.
REQ-032 I_DONE/D_DONE last exactly one cycle with the matching status 2'b10, then IDLE.
REQ-033 Requester drops req the cycle after done; req still high in IDLE is a new request.
REQ-034 Status 2'b01 while req=1 and not done (waiting or in transfer); 2'b00 when req=0 and not done.
REQ-035 Req deasserted mid-transfer: transfer completes; done still reported.
REQ-036 mem_req=0 in IDLE and DONE states; at most one transaction outstanding.
REQ-037 Unbounded mem_ready latency: remain in state indefinitely; no timeout.

Reset
REQ-038 rst=1 forces, asynchronously, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_rvalid=0, i_rdata=0, d_rdata=0, i_status=d_status=2'b00, beat counter=0, d_streak=0.
REQ-039 Reset mid-transfer abandons the transaction; no done or i_rvalid is produced for it.
REQ-040 First arbitration occurs on the first posedge after rst deasserts.

Verification
REQ-041 D read: d_req, d_addr=0x1000, mem_ready after 3 cycles, mem_rdata=0xDEADBEEF -> one mem beat at 0x1000, d_status=2'b10 for 1 cycle, d_rdata=0xDEADBEEF.
REQ-042 I refill: i_addr=0x00400010, mem_ready always 1 -> mem_addr 0x..10,14,18,1C on consecutive cycles, 4 i_rvalid pulses, then i_status=2'b10 once.
REQ-043 Both requesting at once -> D granted first; I granted after D_DONE.
REQ-044 I held high, D re-requesting after each done, MAX_D_STREAK=4 -> exactly 4 D grants, then I grant, then d_streak=0.
REQ-045 rst asserted during beat 2 of a burst -> mem_req=0 and statuses 2'b00 immediately; no i_status=2'b10; next request after rst handled normally.
REQ-046 D write with mem_ready stalled 10 cycles -> mem_we/mem_addr/mem_wdata stable all 10 cycles; d_rdata unchanged; d_status=2'b10 once.
